if_fetch_stage: RTL and testbench

Instruction-fetch stage of the five-stage MIPS pipeline. Owns the program counter and drives the chip-enable and address of the combinational instruction ROM. Latches each fetched word with its PC into the IF/ID pipeline register. Handles sequential advance, ID-stage branch redirect with architectural delay slot, pipeline stalls, exception flush, and misaligned-PC detection.

---
 rtl/if_fetch_stage.sv | 106 ++++++++++
 tb/tb_if_fetch_stage.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives the instruction ROM and fills the
// IF/ID pipeline register with branch redirect, stall, flush and misalignment handling.
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_if,
    input  logic        stall_id,
    input  logic        flush,
    input  logic [31:0] new_pc,
    input  logic        branch_flag,
    input  logic [31:0] branch_target,
    input  logic [31:0] rom_inst,
    output logic        rom_ce,
    output logic [31:0] rom_addr,
    output logic [31:0] id_pc,
    output logic [31:0] id_inst,
    output logic        id_valid,
    output logic        id_adel
);

    logic        ce_q;
    logic [31:0] pc_q,       pc_d;
    logic [31:0] id_pc_q,    id_pc_d;
    logic [31:0] id_inst_q,  id_inst_d;
    logic        id_valid_q, id_valid_d;
    logic        id_adel_q,  id_adel_d;
    logic        misaligned;

    assign misaligned = (pc_q[1:0] != 2'b00);

    // Branch is ignored under stall_if: ID is frozen and will re-present it.
    always_comb begin
        pc_d = pc_q;
        if (!ce_q) begin
            pc_d = RESET_PC;
        end else if (flush) begin
            pc_d = new_pc;
        end else if (stall_if) begin
            pc_d = pc_q;
        end else if (branch_flag) begin
            pc_d = branch_target;
        end else begin
            pc_d = pc_q + 32'd4;
        end
    end

    always_comb begin
        id_pc_d    = id_pc_q;
        id_inst_d  = id_inst_q;
        id_valid_d = id_valid_q;
        id_adel_d  = id_adel_q;
        if (flush) begin
            id_pc_d    = 32'h0;
            id_inst_d  = NOP_INST;
            id_valid_d = 1'b0;
            id_adel_d  = 1'b0;
        end else if (stall_id) begin
            id_pc_d    = id_pc_q;
        end else if (stall_if || !ce_q) begin
            id_pc_d    = 32'h0;
            id_inst_d  = NOP_INST;
            id_valid_d = 1'b0;
            id_adel_d  = 1'b0;
        end else if (misaligned) begin
            // Keep the faulting PC visible so the exception unit can report it.
            id_pc_d    = pc_q;
            id_inst_d  = NOP_INST;
            id_valid_d = 1'b1;
            id_adel_d  = 1'b1;
        end else begin
            id_pc_d    = pc_q;
            id_inst_d  = rom_inst;
            id_valid_d = 1'b1;
            id_adel_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ce_q       <= 1'b0;
            pc_q       <= RESET_PC;
            id_pc_q    <= 32'h0;
            id_inst_q  <= NOP_INST;
            id_valid_q <= 1'b0;
            id_adel_q  <= 1'b0;
        end else begin
            ce_q       <= 1'b1;
            pc_q       <= pc_d;
            id_pc_q    <= id_pc_d;
            id_inst_q  <= id_inst_d;
            id_valid_q <= id_valid_d;
            id_adel_q  <= id_adel_d;
        end
    end

    assign rom_ce   = ce_q;
    assign rom_addr = pc_q;
    assign id_pc    = id_pc_q;
    assign id_inst  = id_inst_q;
    assign id_valid = id_valid_q;
    assign id_adel  = id_adel_q;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Bench for if_fetch_stage: directed scenarios with literal expectations, then random
// stimulus checked every cycle against a behavioural fetch model.
module tb_if_fetch_stage;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP_INST = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        stall_if = 1'b0, stall_id = 1'b0, flush = 1'b0, branch_flag = 1'b0;
    logic [31:0] new_pc = 32'h0, branch_target = 32'h0;
    logic [31:0] rom_inst;
    logic        rom_ce, id_valid, id_adel;
    logic [31:0] rom_addr, id_pc, id_inst;

    int chk_cnt  = 0;
    int pass_cnt = 0;
    bit chk_en   = 1'b0;

    if_fetch_stage #(.RESET_PC(RESET_PC), .NOP_INST(NOP_INST)) dut (
        .clk(clk), .rst(rst), .stall_if(stall_if), .stall_id(stall_id),
        .flush(flush), .new_pc(new_pc), .branch_flag(branch_flag),
        .branch_target(branch_target), .rom_inst(rom_inst), .rom_ce(rom_ce),
        .rom_addr(rom_addr), .id_pc(id_pc), .id_inst(id_inst),
        .id_valid(id_valid), .id_adel(id_adel)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rom_word(input logic [31:0] a);
        return 32'h1000_0000 + (a >> 2);
    endfunction

    assign rom_inst = rom_word(rom_addr);

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    endtask

    // Behavioural model: what the stage holds after each edge.
    logic        m_ce;
    logic [31:0] m_pc, m_idpc, m_inst;
    logic        m_valid, m_adel;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_ce <= 1'b0; m_pc <= RESET_PC;
            m_idpc <= 32'h0; m_inst <= NOP_INST; m_valid <= 1'b0; m_adel <= 1'b0;
        end else begin
            m_ce <= 1'b1;
            if (!m_ce)            m_pc <= RESET_PC;
            else if (flush)       m_pc <= new_pc;
            else if (stall_if)    m_pc <= m_pc;
            else if (branch_flag) m_pc <= branch_target;
            else                  m_pc <= m_pc + 32'd4;

            if (flush || (!stall_id && (stall_if || !m_ce))) begin
                m_idpc <= 32'h0; m_inst <= NOP_INST; m_valid <= 1'b0; m_adel <= 1'b0;
            end else if (!stall_id) begin
                m_idpc  <= m_pc;
                m_valid <= 1'b1;
                m_adel  <= (m_pc % 4) != 0;
                m_inst  <= ((m_pc % 4) != 0) ? NOP_INST : rom_word(m_pc);
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("cmp_rom_ce",   {31'h0, rom_ce},   {31'h0, m_ce});
            chk("cmp_rom_addr", rom_addr,          m_pc);
            chk("cmp_id_pc",    id_pc,             m_idpc);
            chk("cmp_id_inst",  id_inst,           m_inst);
            chk("cmp_id_valid", {31'h0, id_valid}, {31'h0, m_valid});
            chk("cmp_id_adel",  {31'h0, id_adel},  {31'h0, m_adel});
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_ce"},    {31'h0, rom_ce},   32'h0);
        chk({tag, "_addr"},  rom_addr,          RESET_PC);
        chk({tag, "_idpc"},  id_pc,             32'h0);
        chk({tag, "_inst"},  id_inst,           NOP_INST);
        chk({tag, "_valid"}, {31'h0, id_valid}, 32'h0);
        chk({tag, "_adel"},  {31'h0, id_adel},  32'h0);
    endtask

    initial begin
        #1;
        check_reset_vals("por");
        step(); step();
        check_reset_vals("por_hold");
        rst = 1'b1;
        chk_en = 1'b1;

        // Reset release and sequential fetch
        step();
        chk("rel_ce",    {31'h0, rom_ce}, 32'h1);
        chk("rel_addr0", rom_addr, 32'h0);
        chk("rel_bubble", {31'h0, id_valid}, 32'h0);
        step();
        chk("seq_addr4", rom_addr, 32'h4);
        chk("seq_inst0", id_inst, 32'h1000_0000);
        chk("seq_valid", {31'h0, id_valid}, 32'h1);
        step();
        chk("seq_addr8", rom_addr, 32'h8);
        chk("seq_inst1", id_inst, 32'h1000_0001);
        step(); step(); step();
        chk("pc_0x14", rom_addr, 32'h14);

        // Branch with delay slot
        branch_flag = 1'b1; branch_target = 32'h100;
        step();
        branch_flag = 1'b0;
        chk("br_slot_pc",   id_pc, 32'h14);
        chk("br_slot_inst", id_inst, 32'h1000_0005);
        chk("br_target",    rom_addr, 32'h100);
        branch_flag = 1'b1; branch_target = 32'h20;
        step();
        branch_flag = 1'b0;
        chk("br_tgt_inst", id_inst, 32'h1000_0040);

        // Full stall then IF-only stall
        stall_if = 1'b1; stall_id = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_pc",   rom_addr, 32'h20);
            chk("stall_idpc", id_pc, 32'h100);
        end
        stall_id = 1'b0;
        step();
        stall_if = 1'b0;
        chk("stif_valid", {31'h0, id_valid}, 32'h0);
        chk("stif_inst",  id_inst, NOP_INST);
        chk("stif_pc",    rom_addr, 32'h20);

        // Flush beats branch and stall
        flush = 1'b1; new_pc = 32'h180; branch_flag = 1'b1; branch_target = 32'h300;
        stall_if = 1'b1; stall_id = 1'b1;
        step();
        flush = 1'b0; branch_flag = 1'b0; stall_if = 1'b0; stall_id = 1'b0;
        chk("fl_addr",  rom_addr, 32'h180);
        chk("fl_valid", {31'h0, id_valid}, 32'h0);
        chk("fl_idpc",  id_pc, 32'h0);
        step();
        chk("fl_first", id_inst, 32'h1000_0060);

        // Misaligned branch target
        branch_flag = 1'b1; branch_target = 32'h42;
        step();
        branch_flag = 1'b0;
        step();
        chk("adel_pc",   id_pc, 32'h42);
        chk("adel_flag", {31'h0, id_adel}, 32'h1);
        chk("adel_inst", id_inst, NOP_INST);
        chk("adel_next", rom_addr, 32'h46);

        // Asynchronous reset mid-cycle
        branch_flag = 1'b1; branch_target = 32'h200;
        step();
        branch_flag = 1'b0;
        chk("pc_0x200", rom_addr, 32'h200);
        #1 rst = 1'b0;
        #1 check_reset_vals("async");
        step();
        rst = 1'b1;
        step();
        chk("rst_ce",    {31'h0, rom_ce}, 32'h1);
        chk("rst_addr0", rom_addr, RESET_PC);
        step();
        chk("rst_addr4", rom_addr, 32'h4);

        // 32-bit wrap
        branch_flag = 1'b1; branch_target = 32'hFFFF_FFFC;
        step();
        branch_flag = 1'b0;
        step();
        chk("wrap_addr", rom_addr, 32'h0);
        chk("wrap_idpc", id_pc, 32'hFFFF_FFFC);

        // Random phase
        for (int i = 0; i < 3000; i++) begin
            stall_if      = ($urandom_range(0, 9) == 0);
            stall_id      = stall_if && ($urandom_range(0, 1) == 0);
            flush         = ($urandom_range(0, 29) == 0);
            new_pc        = {$urandom_range(0, 1023), 2'b00};
            branch_flag   = ($urandom_range(0, 5) == 0);
            branch_target = ($urandom_range(0, 19) == 0) ? {22'h0, $urandom_range(0, 1023)}
                                                         : {$urandom_range(0, 1023), 2'b00};
            if ($urandom_range(0, 199) == 0) begin
                @(posedge clk);
                #3 rst = 1'b0;
                @(posedge clk);
                #2 rst = 1'b1;
            end else begin
                step();
            end
        end

        stall_if = 1'b0; stall_id = 1'b0; flush = 1'b0; branch_flag = 1'b0;
        step();
        chk_en = 1'b0;
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
